// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU stage: datapath width, op codes, FSM states.
package alu_pkg;

  localparam int unsigned Width   = 8;
  localparam int unsigned ShCntW  = 3;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpAnd = 3'd2,
    OpOr  = 3'd3,
    OpXor = 3'd4,
    OpNot = 3'd5,
    OpShl = 3'd6,
    OpShr = 3'd7
  } alu_op_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StShift = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_logic.sv
// Single-cycle combinational op unit: ops 0-5 plus flag generation.
// Shift op codes pass operand a through with carry 0 (zero-count / shift-disabled case).
module alu_logic
  import alu_pkg::*;
(
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [Width-1:0] res_o,
  output logic             cf_o,
  output logic             zf_o,
  output logic             nf_o
);

  logic [Width:0] sum;

  // Result and carry/borrow for the selected op
  always_comb begin
    sum   = '0;
    res_o = a_i;
    cf_o  = 1'b0;
    case (op_i)
      OpAdd: begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        res_o = sum[Width-1:0];
        cf_o  = sum[Width];
      end
      OpSub: begin
        // Top bit of the widened difference is the borrow (a < b)
        sum   = {1'b0, a_i} - {1'b0, b_i};
        res_o = sum[Width-1:0];
        cf_o  = sum[Width];
      end
      OpAnd:   res_o = a_i & b_i;
      OpOr:    res_o = a_i | b_i;
      OpXor:   res_o = a_i ^ b_i;
      OpNot:   res_o = ~a_i;
      default: begin
        res_o = a_i;
        cf_o  = 1'b0;
      end
    endcase
  end

  assign zf_o = (res_o == '0);
  assign nf_o = res_o[Width-1];

endmodule

// File: rtl/alu_stage.sv
// ALU pipeline stage: latches an op on start, produces result/flags, drives a tri-state bus.
// Optional feature macro ALU_SHIFT_EN: when defined, shifts take one cycle per bit through
// a SHIFT state; when undefined, shift ops complete in one cycle with result = a, cf = 0.
module alu_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             oe,
  output wire logic [Width-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic             nf
);

  alu_op_e          op_e;
  logic [Width-1:0] lu_res;
  logic             lu_cf, lu_zf, lu_nf;

  logic [Width-1:0] result_q, result_d;
  logic             zf_q, zf_d, cf_q, cf_d, nf_q, nf_d;
  logic             done_q, done_d;

  assign op_e = alu_op_e'(op);

  alu_logic u_alu_logic (
    .a_i   (a),
    .b_i   (b),
    .op_i  (op_e),
    .res_o (lu_res),
    .cf_o  (lu_cf),
    .zf_o  (lu_zf),
    .nf_o  (lu_nf)
  );

`ifdef ALU_SHIFT_EN
  alu_state_e        state_q, state_d;
  logic [Width-1:0]  sh_q, sh_d;
  logic [ShCntW-1:0] cnt_q, cnt_d;
  logic              shl_q, shl_d;
  logic [Width-1:0]  sh_next;
  logic              sh_out;
  logic              is_shift;

  assign is_shift = (op_e == OpShl) || (op_e == OpShr);

  // One-bit shift step and the bit falling off the end
  always_comb begin
    sh_next = shl_q ? {sh_q[Width-2:0], 1'b0} : {1'b0, sh_q[Width-1:1]};
    sh_out  = shl_q ? sh_q[Width-1] : sh_q[0];
  end

  // Next-state: accept start in idle, step the shifter, publish on completion
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    shl_d    = shl_q;
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    nf_d     = nf_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (is_shift && (b[ShCntW-1:0] != '0)) begin
            state_d = StShift;
            sh_d    = a;
            cnt_d   = b[ShCntW-1:0];
            shl_d   = (op_e == OpShl);
          end else begin
            result_d = lu_res;
            zf_d     = lu_zf;
            cf_d     = lu_cf;
            nf_d     = lu_nf;
            done_d   = 1'b1;
          end
        end
      end
      StShift: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == ShCntW'(1)) begin
          state_d  = StIdle;
          result_d = sh_next;
          zf_d     = (sh_next == '0);
          cf_d     = sh_out;
          nf_d     = sh_next[Width-1];
          done_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shifter FSM registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      shl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      shl_q   <= shl_d;
    end
  end

  assign busy = (state_q == StShift);
`else
  // Next-state: every op, shifts included, completes in the cycle it is accepted
  always_comb begin
    result_d = result_q;
    zf_d     = zf_q;
    cf_d     = cf_q;
    nf_d     = nf_q;
    done_d   = 1'b0;
    if (start) begin
      result_d = lu_res;
      zf_d     = lu_zf;
      cf_d     = lu_cf;
      nf_d     = lu_nf;
      done_d   = 1'b1;
    end
  end

  assign busy = 1'b0;
`endif

  // Result, flag and done registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      nf_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      nf_q     <= nf_d;
      done_q   <= done_d;
    end
  end

  assign q    = oe ? {Width{1'bz}} : result_q;
  assign done = done_q;
  assign zf   = zf_q;
  assign cf   = cf_q;
  assign nf   = nf_q;

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed cases then random ops against an
// arithmetic reference model. Works for builds with or without ALU_SHIFT_EN.
module tb_alu_stage;

`ifdef ALU_SHIFT_EN
  localparam bit ShiftEn = 1'b1;
`else
  localparam bit ShiftEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       start, oe;
  wire  [7:0] q;
  logic       busy, done, zf, cf, nf;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_res;
  logic       exp_zf, exp_cf, exp_nf;

  // Weak pull so a released bus reads 0
  for (genvar gi = 0; gi < 8; gi++) begin : g_pd
    pulldown (q[gi]);
  end

  alu_stage dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .oe    (oe),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .zf    (zf),
    .cf    (cf),
    .nf    (nf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, expv);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, expv);
    end
  endtask

  // Reference: result, carry and cycles spent busy for one op
  function automatic void model(input int opc, input int av, input int bv,
                                output int res, output int c, output int lat);
    int k;
    k   = bv % 8;
    lat = 0;
    c   = 0;
    case (opc)
      0: begin res = (av + bv) % 256; c = (av + bv > 255) ? 1 : 0; end
      1: begin res = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
      2: res = av & bv;
      3: res = av | bv;
      4: res = av ^ bv;
      5: res = 255 - av;
      6: begin
        if (ShiftEn && k != 0) begin
          res = (av * (1 << k)) % 256;
          c   = (av / (1 << (8 - k))) % 2;
          lat = k;
        end else res = av;
      end
      default: begin
        if (ShiftEn && k != 0) begin
          res = av / (1 << k);
          c   = (av / (1 << (k - 1))) % 2;
          lat = k;
        end else res = av;
      end
    endcase
  endfunction

  // Issue one op from a negedge; junk/ADD starts are thrown at it while busy
  task automatic run_op(input int opc, input int av, input int bv);
    int res, c, lat;
    model(opc, av, bv, res, c, lat);
    a = 8'(av); b = 8'(bv); op = 3'(opc); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= lat; i++) begin
      check1("busy_during", busy, 1'b1);
      check1("done_during", done, 1'b0);
      check8("q_hold", q, exp_res);
      a     = 8'($urandom);
      b     = 8'($urandom);
      op    = (i == 1) ? 3'd0 : 3'($urandom);
      start = (i == 1) ? 1'b1 : 1'($urandom);
      @(negedge clk);
    end
    exp_res = 8'(res);
    exp_cf  = (c != 0);
    exp_zf  = (res == 0);
    exp_nf  = (res >= 128);
    check1("done", done, 1'b1);
    check1("busy_after", busy, 1'b0);
    check8("q", q, exp_res);
    check1("zf", zf, exp_zf);
    check1("cf", cf, exp_cf);
    check1("nf", nf, exp_nf);
    start = 1'b0;
    @(negedge clk);
    check1("done_pulse", done, 1'b0);
    check8("q_stable", q, exp_res);
  endtask

  initial begin
    int res, c, lat;
    rst = 1'b1; start = 1'b0; oe = 1'b0; a = '0; b = '0; op = '0;
    exp_res = '0; exp_zf = 1'b0; exp_cf = 1'b0; exp_nf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check8("rst_q", q, 8'h00);
    check1("rst_zf", zf, 1'b0);
    check1("rst_cf", cf, 1'b0);
    check1("rst_nf", nf, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // ADD wrap with carry, SUB borrow
    run_op(0, 8'hFF, 8'h01);
    run_op(1, 8'h10, 8'h20);
    oe = 1'b1;
    #1 check8("q_released", q, 8'h00);
    oe = 1'b0;
    #1 check8("q_redriven", q, 8'hF0);

    // Shifts: multi-cycle, single-bit, long shift with ADD start during busy
    run_op(6, 8'h81, 8'h03);
    run_op(7, 8'h81, 8'h01);
    run_op(6, 8'hA7, 8'h05);
    run_op(6, 8'h55, 8'h02);
    run_op(7, 8'hC3, 8'h08);

    // Reset in the second shift cycle aborts with no done pulse
    model(6, 8'h0F, 8'h04, res, c, lat);
    a = 8'h0F; b = 8'h04; op = 3'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1; op = 3'd0;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    exp_res = '0; exp_zf = 1'b0; exp_cf = 1'b0; exp_nf = 1'b0;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check8("abort_q", q, 8'h00);
    check1("abort_zf", zf, 1'b0);
    check1("abort_cf", cf, 1'b0);
    check1("abort_nf", nf, 1'b0);
    @(negedge clk);
    check1("abort_no_late_done", done, 1'b0);
    run_op(2, 8'hF0, 8'h3C);

    // Random ops
    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
ALU_STAGE -- requirements
Module: alu_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: a  in  8  operand from register bus A.
REQ-004 SHALL have: b  in  8  operand from register bus B; b[2:0] is the shift count for shift ops.
REQ-005 SHALL have: op  in  3  operation code, sampled with start.
REQ-006 SHALL have: start  in  1  begin operation; sampled only when not busy.
REQ-007 SHALL have: oe  in  1  active-low output enable for q.
REQ-008 SHALL have: q  out(tri)  8  result; high-Z when oe=1; drives the register load bus (di).
REQ-009 SHALL have: busy  out  1  operation in progress.
REQ-010 SHALL have: done  out  1  one-cycle completion pulse.
REQ-011 SHALL have: zf, cf, nf  out  1 each  zero, carry/borrow, negative flags of last completed op.

Function
REQ-012 Ops SHALL be: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 SHL a by b[2:0]; 7 SHR (logical) a by b[2:0].
REQ-013 FSM states SHALL be IDLE, SHIFT; start accepted only in IDLE with busy=0.
REQ-014 Ops 0-5 and shifts with count 0: operands latched at edge N; result, flags updated at edge N; done=1 for the cycle after edge N; busy stays 0.
REQ-015 Shift with count k>=1: edge N loads a and k, enters SHIFT, busy=1; one bit per edge N+1..N+k; at edge N+k result/flags update, done=1, busy=0, return to IDLE.
REQ-016 Result and flags SHALL hold unchanged between completions; operand/op changes while busy SHALL be ignored.
REQ-017 start while busy SHALL be ignored (not queued).
REQ-018 ADD: cf = bit-8 carry; SUB: cf = 1 when a<b (borrow); logic ops and NOT: cf=0; shifts: cf = last bit shifted out, 0 for count 0.
REQ-019 zf = (result==0); nf = result[7]; all results 8-bit, wrap modulo 256.
REQ-020 q SHALL equal the registered result whenever oe=0, independent of busy/done.

Reset
REQ-021 rst=1 at an edge SHALL force: state IDLE, result 0x00, zf=cf=nf=0, busy=0, done=0, shift count 0.
REQ-022 rst during SHIFT SHALL abort the op with no done pulse; rst has priority over start.

Configuration
REQ-023 Macro ALU_SHIFT_EN: defined -> ops 6/7 behave per REQ-015; undefined -> SHIFT state and shift counter absent, ops 6/7 complete in one cycle with result=a, cf=0.

Structure
REQ-024 Shared package alu_pkg SHALL hold the op-code enum, FSM state enum and width constant (8).
REQ-025 Combinational op unit SHALL be sub-module alu_logic (ops 0-5, flag generation); FSM, shift register, tri-state output in alu_stage.

Verification
REQ-026 ADD a=0xFF b=0x01 start -> next cycle done=1, q=0x00, zf=1, cf=1, nf=0, busy=0.
REQ-027 SUB a=0x10 b=0x20 -> q=0xF0, cf=1, nf=1, zf=0; oe=1 -> q all Z.
REQ-028 SHL a=0x81 b=0x03 (ALU_SHIFT_EN) -> busy 3 cycles, done in the cycle after the 3rd shift edge, q=0x08, cf=0; SHR a=0x81 b=0x01 -> q=0x40, cf=1.
REQ-029 start pulsed with op=ADD during a 5-cycle shift -> ignored; only the shift's done pulse, result unchanged by ADD.
REQ-030 rst asserted in 2nd shift cycle -> next cycle busy=0, done=0, q=0x00, flags 0; subsequent AND 0xF0&0x3C -> q=0x30.
REQ-031 Build without ALU_SHIFT_EN: SHL a=0x55 b=0x02 -> one-cycle done, q=0x55, cf=0.
